// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: fetch-side bus bundle (imem request/response, decode handshake, redirects, counter)
//   master: driven by fetch_sequencer (req valid/addr, if_valid/pc/instr, fetch_count)
//   slave:  driven by memory/decode/control (req ready, response, if_ready, redirect requests and targets)
interface fetch_sequencer_if #(parameter int ADDR_W = 32);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_resp_valid;
  logic [31:0]       imem_resp_data;
  logic              if_valid;
  logic              if_ready;
  logic [ADDR_W-1:0] if_pc;
  logic [31:0]       if_instr;
  logic              trap_req;
  logic [ADDR_W-1:0] trap_vector;
  logic              mret_req;
  logic [ADDR_W-1:0] mret_target;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic [31:0]       fetch_count;
  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, fetch_count,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, if_ready,
           trap_req, trap_vector, mret_req, mret_target, branch_taken, branch_target
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, fetch_count,
    output imem_req_ready, imem_resp_valid, imem_resp_data, if_ready,
           trap_req, trap_vector, mret_req, mret_target, branch_taken, branch_target
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner and handshaked IF-stage fetch loop with prioritised redirects
//   clk, rst: clock and synchronous active-high reset
//   bus (master): imem request/response, decode handshake, redirect inputs, fetch_count
module fetch_sequencer #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input logic              clk,
  input logic              rst,
  fetch_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, if_pc_q, if_pc_d, target;
  logic [31:0]       if_instr_q, if_instr_d, fetch_count_q, fetch_count_d;
  logic              redirect, resp;
  always_comb begin
    redirect      = bus.trap_req | bus.mret_req | bus.branch_taken;
    target        = (bus.trap_req ? bus.trap_vector : bus.mret_req ? bus.mret_target : bus.branch_target)
                    & ~ADDR_W'(3);
    resp          = bus.imem_resp_valid;
    state_d       = state_q;
    pc_d          = pc_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: if (bus.imem_req_ready) begin
        if_pc_d = pc_q;
        // an accepted request that is redirected away must still be drained
        state_d = redirect ? DRAIN : WAIT;
      end
      WAIT: begin
        // a response coinciding with a redirect is stale and closes the transaction
        if_instr_d = resp && !redirect ? bus.imem_resp_data : if_instr_q;
        state_d    = resp ? (redirect ? REQ : HOLD) : (redirect ? DRAIN : WAIT);
      end
      HOLD: if (redirect) state_d = REQ;
      else if (bus.if_ready) begin
        pc_d          = if_pc_q + ADDR_W'(4);
        fetch_count_d = fetch_count_q + 32'd1;
        state_d       = REQ;
      end
      DRAIN: state_d = resp ? REQ : DRAIN;
      default: state_d = IDLE;
    endcase
    pc_d = redirect ? target : pc_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_VECTOR;
      if_pc_q       <= '0;
      if_instr_q    <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      fetch_count_q <= fetch_count_d;
    end
  end
  assign bus.imem_req_valid = state_q == REQ;
  assign bus.imem_req_addr  = pc_q;
  assign bus.if_valid       = state_q == HOLD;
  assign bus.if_pc          = if_pc_q;
  assign bus.if_instr       = if_instr_q;
  assign bus.fetch_count    = fetch_count_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench for fetch_sequencer with a delayed-response memory model
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  fetch_sequencer_if #(.ADDR_W(32)) bus();
  fetch_sequencer #(.ADDR_W(32), .RESET_VECTOR(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));
  int          n_pass, n_tot;
  logic [31:0] exp_req[$];
  logic [31:0] exp_fetch[$];
  bit          pending;
  int          cnt, delay;
  logic [31:0] pend_addr;
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h1300_0013;
  endfunction
  // one clock: memory model + scoreboard run at the negedge, then advance to the next negedge
  task automatic cyc();
    logic [31:0] e;
    bit          redir;
    redir = bus.trap_req | bus.mret_req | bus.branch_taken;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    if (pending) begin
      if (cnt == 0) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = memf(pend_addr);
        pending = 1'b0;
      end else cnt--;
    end
    if (!rst && bus.imem_req_valid && bus.imem_req_ready) begin
      pending = 1'b1; cnt = delay - 1; pend_addr = bus.imem_req_addr;
      n_tot++;
      if (exp_req.size() == 0) $display("FAIL req_addr: got unexpected request %h, want none", bus.imem_req_addr);
      else begin
        e = exp_req.pop_front();
        if (bus.imem_req_addr !== e) $display("FAIL req_addr: got %h want %h", bus.imem_req_addr, e);
        else n_pass++;
      end
    end
    if (!rst && !redir && bus.if_valid && bus.if_ready) begin
      n_tot++;
      if (exp_fetch.size() == 0) $display("FAIL fetch: got unexpected pc %h, want none", bus.if_pc);
      else begin
        e = exp_fetch.pop_front();
        if (bus.if_pc !== e || bus.if_instr !== memf(e))
          $display("FAIL fetch: got pc %h instr %h want pc %h instr %h", bus.if_pc, bus.if_instr, e, memf(e));
        else n_pass++;
      end
    end
    @(negedge clk);
  endtask
  task automatic test_reset();
    cyc(); cyc();
    n_tot++; if (bus.imem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid); else n_pass++;
    n_tot++; if (bus.imem_req_addr !== 32'h0) $display("FAIL reset_pc: got %h want 0", bus.imem_req_addr); else n_pass++;
    n_tot++; if (bus.if_valid !== 1'b0) $display("FAIL reset_if_valid: got %b want 0", bus.if_valid); else n_pass++;
    n_tot++; if (bus.if_pc !== 32'h0 || bus.if_instr !== 32'h0) $display("FAIL reset_if: got pc %h instr %h want 0 0", bus.if_pc, bus.if_instr); else n_pass++;
    n_tot++; if (bus.fetch_count !== 32'h0) $display("FAIL reset_count: got %0d want 0", bus.fetch_count); else n_pass++;
    rst = 1'b0;
  endtask
  task automatic test_sequential();
    bus.imem_req_ready = 1'b1; bus.if_ready = 1'b1; delay = 1;
    exp_req.push_back(32'h0); exp_req.push_back(32'h4);
    exp_fetch.push_back(32'h0); exp_fetch.push_back(32'h4);
    for (int i = 0; i < 40 && bus.fetch_count != 32'd2; i++) cyc();
    n_tot++; if (bus.fetch_count !== 32'd2) $display("FAIL seq_count: got %0d want 2", bus.fetch_count); else n_pass++;
  endtask
  task automatic test_hold();
    exp_req.push_back(32'h8);
    bus.if_ready = 1'b0;
    for (int i = 0; i < 20 && bus.if_valid !== 1'b1; i++) cyc();
    n_tot++; if (bus.if_valid !== 1'b1) $display("FAIL hold_reach: got if_valid %b want 1", bus.if_valid); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_tot++;
      if ({bus.if_valid, bus.imem_req_valid, bus.if_pc, bus.if_instr, bus.fetch_count} !== {1'b1, 1'b0, 32'h8, memf(32'h8), 32'd2})
        $display("FAIL hold_stable: got v %b req %b pc %h instr %h cnt %0d want 1 0 00000008 %h 2",
                 bus.if_valid, bus.imem_req_valid, bus.if_pc, bus.if_instr, bus.fetch_count, memf(32'h8));
      else n_pass++;
    end
    exp_fetch.push_back(32'h8);
    bus.if_ready = 1'b1;
    cyc();
    n_tot++; if (bus.fetch_count !== 32'd3) $display("FAIL hold_count: got %0d want 3", bus.fetch_count); else n_pass++;
  endtask
  task automatic test_branch_drain();
    delay = 2;
    exp_req.push_back(32'hC);
    n_tot++; if (bus.imem_req_valid !== 1'b1) $display("FAIL drain_pre: got req_valid %b want 1", bus.imem_req_valid); else n_pass++;
    cyc();
    bus.branch_taken = 1'b1; bus.branch_target = 32'h103;
    cyc();
    bus.branch_taken = 1'b0;
    n_tot++; if (bus.imem_req_valid !== 1'b0 || bus.if_valid !== 1'b0) $display("FAIL drain_state: got req %b if_valid %b want 0 0", bus.imem_req_valid, bus.if_valid); else n_pass++;
    cyc();
    n_tot++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100) $display("FAIL drain_next: got req %b addr %h want 1 00000100", bus.imem_req_valid, bus.imem_req_addr); else n_pass++;
    delay = 1;
    exp_req.push_back(32'h100); exp_fetch.push_back(32'h100);
    for (int i = 0; i < 20 && bus.fetch_count != 32'd4; i++) cyc();
    n_tot++; if (bus.fetch_count !== 32'd4) $display("FAIL drain_count: got %0d want 4", bus.fetch_count); else n_pass++;
  endtask
  task automatic test_priority();
    bus.imem_req_ready = 1'b0;
    bus.trap_req = 1'b1; bus.mret_req = 1'b1; bus.branch_taken = 1'b1;
    bus.trap_vector = 32'h200; bus.mret_target = 32'h300; bus.branch_target = 32'h400;
    cyc();
    bus.trap_req = 1'b0; bus.mret_req = 1'b0; bus.branch_taken = 1'b0;
    n_tot++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h200) $display("FAIL priority: got req %b addr %h want 1 00000200", bus.imem_req_valid, bus.imem_req_addr); else n_pass++;
    bus.imem_req_ready = 1'b1;
    exp_req.push_back(32'h200); exp_fetch.push_back(32'h200);
    for (int i = 0; i < 20 && bus.fetch_count != 32'd5; i++) cyc();
    n_tot++; if (bus.fetch_count !== 32'd5) $display("FAIL priority_count: got %0d want 5", bus.fetch_count); else n_pass++;
  endtask
  task automatic test_hold_redirect();
    exp_req.push_back(32'h204);
    bus.if_ready = 1'b0;
    for (int i = 0; i < 20 && bus.if_valid !== 1'b1; i++) cyc();
    n_tot++; if (bus.if_valid !== 1'b1) $display("FAIL hredir_reach: got if_valid %b want 1", bus.if_valid); else n_pass++;
    bus.branch_taken = 1'b1; bus.branch_target = 32'h40; bus.if_ready = 1'b1;
    cyc();
    bus.branch_taken = 1'b0;
    n_tot++;
    if ({bus.if_valid, bus.imem_req_valid, bus.imem_req_addr, bus.fetch_count} !== {1'b0, 1'b1, 32'h40, 32'd5})
      $display("FAIL hredir: got v %b req %b addr %h cnt %0d want 0 1 00000040 5", bus.if_valid, bus.imem_req_valid, bus.imem_req_addr, bus.fetch_count);
    else n_pass++;
    exp_req.push_back(32'h40); exp_fetch.push_back(32'h40);
    for (int i = 0; i < 20 && bus.fetch_count != 32'd6; i++) cyc();
    n_tot++; if (bus.fetch_count !== 32'd6) $display("FAIL hredir_count: got %0d want 6", bus.fetch_count); else n_pass++;
  endtask
  task automatic test_stall_redirect_reset();
    bus.imem_req_ready = 1'b0;
    bus.branch_taken = 1'b1; bus.branch_target = 32'h10;
    cyc();
    bus.branch_taken = 1'b0;
    cyc();
    n_tot++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h10) $display("FAIL stall_addr: got req %b addr %h want 1 00000010", bus.imem_req_valid, bus.imem_req_addr); else n_pass++;
    bus.branch_taken = 1'b1; bus.branch_target = 32'h80;
    cyc();
    bus.branch_taken = 1'b0;
    n_tot++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h80) $display("FAIL stall_redir: got req %b addr %h want 1 00000080", bus.imem_req_valid, bus.imem_req_addr); else n_pass++;
    exp_req.push_back(32'h80);
    delay = 3; bus.imem_req_ready = 1'b1;
    cyc();
    bus.imem_req_ready = 1'b0;
    n_tot++; if (bus.imem_req_valid !== 1'b0) $display("FAIL wait_state: got req %b want 0", bus.imem_req_valid); else n_pass++;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_tot++;
    if ({bus.imem_req_valid, bus.if_valid, bus.fetch_count} !== {1'b0, 1'b0, 32'd0})
      $display("FAIL midreset: got req %b v %b cnt %0d want 0 0 0", bus.imem_req_valid, bus.if_valid, bus.fetch_count);
    else n_pass++;
    cyc();
    n_tot++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) $display("FAIL midreset_req: got req %b addr %h want 1 00000000", bus.imem_req_valid, bus.imem_req_addr); else n_pass++;
    cyc(); cyc();
    n_tot++;
    if ({bus.imem_req_valid, bus.if_valid, bus.imem_req_addr} !== {1'b1, 1'b0, 32'h0})
      $display("FAIL stale_resp: got req %b v %b addr %h want 1 0 00000000", bus.imem_req_valid, bus.if_valid, bus.imem_req_addr);
    else n_pass++;
    delay = 1; bus.imem_req_ready = 1'b1;
    exp_req.push_back(32'h0); exp_fetch.push_back(32'h0);
    for (int i = 0; i < 20 && bus.fetch_count != 32'd1; i++) cyc();
    n_tot++; if (bus.fetch_count !== 32'd1) $display("FAIL midreset_count: got %0d want 1", bus.fetch_count); else n_pass++;
  endtask
  task automatic test_wrap();
    bus.imem_req_ready = 1'b0;
    bus.branch_taken = 1'b1; bus.branch_target = 32'hFFFF_FFFF;
    cyc();
    bus.branch_taken = 1'b0;
    n_tot++; if (bus.imem_req_addr !== 32'hFFFF_FFFC) $display("FAIL align: got %h want fffffffc", bus.imem_req_addr); else n_pass++;
    exp_req.push_back(32'hFFFF_FFFC); exp_fetch.push_back(32'hFFFF_FFFC);
    bus.imem_req_ready = 1'b1;
    for (int i = 0; i < 20 && bus.fetch_count != 32'd2; i++) cyc();
    n_tot++;
    if ({bus.fetch_count, bus.imem_req_valid, bus.imem_req_addr} !== {32'd2, 1'b1, 32'h0})
      $display("FAIL wrap: got cnt %0d req %b addr %h want 2 1 00000000", bus.fetch_count, bus.imem_req_valid, bus.imem_req_addr);
    else n_pass++;
  endtask
  task automatic test_end();
    n_tot++; if (exp_req.size() != 0) $display("FAIL req_left: got %0d pending want 0", exp_req.size()); else n_pass++;
    n_tot++; if (exp_fetch.size() != 0) $display("FAIL fetch_left: got %0d pending want 0", exp_fetch.size()); else n_pass++;
  endtask
  initial begin
    n_pass = 0; n_tot = 0; pending = 1'b0; cnt = 0; delay = 1; pend_addr = '0;
    rst = 1'b1;
    bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0; bus.imem_resp_data = '0; bus.if_ready = 1'b0;
    bus.trap_req = 1'b0; bus.mret_req = 1'b0; bus.branch_taken = 1'b0;
    bus.trap_vector = '0; bus.mret_target = '0; bus.branch_target = '0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_hold();
    test_branch_drain();
    test_priority();
    test_hold_redirect();
    test_stall_redirect_reset();
    test_wrap();
    test_end();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the program counter and sequences instruction fetch between the PC, the instruction memory port and decode.
- Arbitrates the redirect sources (trap, mret, taken branch/jump) by fixed priority.
- Tracks a single outstanding memory request and discards stale responses after a redirect.
- Sits in the IF stage, replacing a free-running PC increment with a handshaked fetch loop.

Parameters:
- ADDR_W, 32, instruction address width.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request; transfer when valid&&ready.
- imem_req_addr  out  ADDR_W  fetch address; equals current PC.
- imem_resp_valid  in  1  response for the accepted request; one-cycle pulse.
- imem_resp_data  in  32  instruction word.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts; transfer when if_valid&&if_ready.
- if_pc  out  ADDR_W  address of the presented instruction.
- if_instr  out  32  presented instruction.
- trap_req  in  1  redirect to trap_vector (priority 1, highest).
- trap_vector  in  ADDR_W  trap target.
- mret_req  in  1  redirect to mret_target (priority 2).
- mret_target  in  ADDR_W  return target.
- branch_taken  in  1  redirect to branch_target (priority 3).
- branch_target  in  ADDR_W  branch/jump target.
- fetch_count  out  32  count of instructions delivered to decode.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc=RESET_VECTOR, state=IDLE, if_valid=0, if_pc=0, if_instr=0, fetch_count=0.
  - imem_req_valid=0 while in IDLE.
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
  - imem_req_valid=1 only in REQ.
  - if_valid=1 only in HOLD.
- IDLE: unconditionally go to REQ on the next edge after reset deasserts.
- REQ: on valid&&ready, record if_pc<=pc and go to WAIT. Otherwise stay in REQ.
- WAIT: on imem_resp_valid, if_instr<=imem_resp_data and go to HOLD.
- HOLD: on if_ready, pc<=if_pc+4, fetch_count+=1 (wraps at 2^32), and go to REQ.
  - Latency: request accept to if_valid is 1 cycle after resp_valid.
  - A zero-wait memory gives one instruction per 3 cycles.
- Redirect:
  - redirect = trap_req|mret_req|branch_taken.
  - Target is chosen by priority trap > mret > branch; lower-priority requests in the same cycle are ignored.
  - Target bits [1:0] are forced to 0.
  - On redirect, pc<=target in all states, and the redirect overrides the normal pc update.
- Redirect next-state by state:
  - IDLE: go to REQ.
  - REQ, not accepted this cycle: stay in REQ with the new address. Changing or retracting an unaccepted request is legal on this interface; memory samples only on valid&&ready.
  - REQ, accepted this cycle: go to DRAIN; the accepted request is stale.
  - WAIT with resp_valid in the same cycle: discard the response and go to REQ.
  - WAIT without resp_valid: go to DRAIN.
  - HOLD: if_valid drops next cycle and the instruction is not counted, even if if_ready=1 in the same cycle. Go to REQ.
  - DRAIN: on resp_valid, discard and go to REQ. A further redirect in DRAIN updates pc and keeps the state in DRAIN until the response arrives.
- Invariants:
  - At most one request is outstanding.
  - A response arriving in IDLE, REQ or HOLD is a protocol error; ignore it.
  - pc+4 wraps modulo 2^ADDR_W.
- Reset mid-operation: return to IDLE. Any outstanding response after reset is ignored, since state is IDLE/REQ and not WAIT.

Test Plan:
- Reset, then memory with ready=1 and responses one cycle after accept; if_ready=1 -> req addrs 0x0, 0x4, 0x8; if_pc matches; fetch_count=3 after three HOLD handshakes.
- if_ready=0 for 5 cycles in HOLD at pc 0x8 -> if_valid held with if_pc=0x8 and instr stable; no new request; count unchanged until accept.
- branch_taken=1 with target 0x103 in WAIT, response 2 cycles later -> DRAIN, response discarded, next req addr 0x100, if_pc=0x100.
- trap_req, mret_req and branch_taken asserted together with trap_vector=0x200, mret_target=0x300, branch_target=0x400 -> next req addr 0x200.
- Redirect to 0x40 in HOLD with if_ready=1 the same cycle -> instruction not counted; next req addr 0x40.
- imem_req_ready=0 in REQ at 0x10, then branch to 0x80 -> req addr changes to 0x80 next cycle with no DRAIN; assert rst mid-WAIT -> req addr returns to 0x0.
